// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny streaming pipeline.
// GAUSSIAN_ROUND_EN widens the blur accumulator for round-half-up.
package canny_pkg;

    localparam int PIXEL_W = 8;
    localparam int SUM_W   = 12;

`ifdef GAUSSIAN_ROUND_EN
    localparam int ACC_W = SUM_W + 1;
`else
    localparam int ACC_W = SUM_W;
`endif

    typedef enum logic [1:0] {
        PRIME,
        RUN,
        FLUSH
    } state_t;

    localparam logic [ACC_W-1:0] K_CORNER = ACC_W'(1);
    localparam logic [ACC_W-1:0] K_EDGE   = ACC_W'(2);
    localparam logic [ACC_W-1:0] K_CENTRE = ACC_W'(4);

    // 3x3 window, row-major: index r*3+c, row 0 is the oldest line
    typedef logic [8:0][PIXEL_W-1:0] win_t;

    function automatic logic [ACC_W-1:0] ext(input logic [PIXEL_W-1:0] p);
        return ACC_W'(p);
    endfunction

    function automatic logic [ACC_W-1:0] gauss_sum(input win_t w);
        logic [ACC_W-1:0] c;
        logic [ACC_W-1:0] e;
        c = ext(w[0]) + ext(w[2]) + ext(w[6]) + ext(w[8]);
        e = ext(w[1]) + ext(w[3]) + ext(w[5]) + ext(w[7]);
        return K_CORNER * c + K_EDGE * e + K_CENTRE * ext(w[4]);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One-line delay for the blur window: the value read is the one
// written DEPTH steps earlier. Contents are not reset.
module line_buffer
    import canny_pkg::*;
#(
    parameter int DEPTH = 640
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic [PIXEL_W-1:0] din_i,
    output logic [PIXEL_W-1:0] dout_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;
    logic [PIXEL_W-1:0] mem_q [DEPTH];

    assign ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    assign dout_o = mem_q[ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (en_i) begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/gaussian_blur_stream.sv
// Streaming 3x3 Gaussian blur: prime / run / flush per frame.
// Optional GAUSSIAN_ROUND_EN selects round-half-up with saturation.
module gaussian_blur_stream
    import canny_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_empty,
    input  logic [PIXEL_W-1:0] in_dout,
    output logic               in_rd_en,
    input  logic               out_full,
    output logic               out_wr_en,
    output logic [PIXEL_W-1:0] out_din,
    output logic               busy
);

    localparam int CNT_W = $clog2(WIDTH * HEIGHT);
    localparam int ROW_W = $clog2(HEIGHT);
    localparam int COL_W = $clog2(WIDTH);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ROW_W-1:0]        crow_q, crow_d;
    logic [COL_W-1:0]        ccol_q, ccol_d;
    logic [2:0][PIXEL_W-1:0] col1_q, col2_q;
    logic [PIXEL_W-1:0]      out_din_q, out_din_d;
    logic                    out_valid_q, out_valid_d;
    logic                    busy_q, busy_d;
    logic                    last_q, last_d;

    logic               adv;
    logic               emit;
    logic               frame_end;
    logic               first_rd;
    logic               border;
    logic [PIXEL_W-1:0] px;
    logic [PIXEL_W-1:0] tap1;
    logic [PIXEL_W-1:0] tap2;
    logic [PIXEL_W-1:0] blur;
    logic [ACC_W-1:0]   sum;
    logic               unused_lsb;
    win_t               win;

    assign adv = (~out_valid_q | ~out_full)
               & ((state_q == FLUSH) | ~in_empty);
    assign emit      = adv & (state_q != PRIME);
    assign in_rd_en  = adv & (state_q != FLUSH);
    assign out_wr_en = out_valid_q & ~out_full;
    assign out_din   = out_din_q;
    assign busy      = busy_q;
    assign px        = (state_q == FLUSH) ? '0 : in_dout;
    assign first_rd  = in_rd_en & (state_q == PRIME) & (cnt_q == '0);

    line_buffer #(.DEPTH(WIDTH)) u_lb1 (
        .clk    (clk),
        .rst    (rst),
        .en_i   (adv),
        .din_i  (px),
        .dout_o (tap1)
    );

    line_buffer #(.DEPTH(WIDTH)) u_lb2 (
        .clk    (clk),
        .rst    (rst),
        .en_i   (adv),
        .din_i  (tap1),
        .dout_o (tap2)
    );

    // Window as it stands after this step's shift
    always_comb begin
        win[0] = col1_q[0];
        win[1] = col2_q[0];
        win[2] = tap2;
        win[3] = col1_q[1];
        win[4] = col2_q[1];
        win[5] = tap1;
        win[6] = col1_q[2];
        win[7] = col2_q[2];
        win[8] = px;
    end

    assign sum        = gauss_sum(win);
    assign unused_lsb = ^sum[3:0];

`ifdef GAUSSIAN_ROUND_EN
    logic [ACC_W-1:0] sum_r;
    assign sum_r = sum + ACC_W'(8);
    assign blur  = sum_r[SUM_W] ? '1 : sum_r[SUM_W-1:4];
`else
    assign blur = sum[SUM_W-1:4];
`endif

    assign border = (crow_q == '0) | (crow_q == ROW_W'(HEIGHT - 1))
                  | (ccol_q == '0) | (ccol_q == COL_W'(WIDTH - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        crow_d    = crow_q;
        ccol_d    = ccol_q;
        frame_end = 1'b0;
        if (adv) begin
            cnt_d = cnt_q + 1'b1;
            unique case (state_q)
                PRIME: begin
                    if (cnt_q == CNT_W'(WIDTH)) state_d = RUN;
                end
                RUN: begin
                    if (cnt_q == CNT_W'(WIDTH * HEIGHT - 1)) begin
                        state_d = FLUSH;
                        cnt_d   = '0;
                    end
                end
                FLUSH: begin
                    if (cnt_q == CNT_W'(WIDTH)) begin
                        state_d   = PRIME;
                        cnt_d     = '0;
                        frame_end = 1'b1;
                    end
                end
                default: state_d = PRIME;
            endcase
            if (emit) begin
                if (ccol_q == COL_W'(WIDTH - 1)) begin
                    ccol_d = '0;
                    crow_d = (crow_q == ROW_W'(HEIGHT - 1)) ? '0 : crow_q + 1'b1;
                end else begin
                    ccol_d = ccol_q + 1'b1;
                end
            end
            if (frame_end) begin
                crow_d = '0;
                ccol_d = '0;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_din_d   = out_din_q;
        last_d      = last_q;
        busy_d      = busy_q;
        if (emit) begin
            out_valid_d = 1'b1;
            out_din_d   = border ? '0 : blur;
            last_d      = frame_end;
        end else if (out_wr_en) begin
            out_valid_d = 1'b0;
            last_d      = 1'b0;
        end
        // A new frame's first read may coincide with the old frame's last write
        if (first_rd) begin
            busy_d = 1'b1;
        end else if (out_wr_en & last_q) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PRIME;
            cnt_q       <= '0;
            crow_q      <= '0;
            ccol_q      <= '0;
            col1_q      <= '0;
            col2_q      <= '0;
            out_din_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            crow_q      <= crow_d;
            ccol_q      <= ccol_d;
            out_din_q   <= out_din_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            last_q      <= last_d;
            if (adv) begin
                col1_q <= col2_q;
                col2_q <= {px, tap1, tap2};
            end
        end
    end

endmodule

// File: tb/tb_gaussian_blur_stream.sv
// Scoreboard bench for gaussian_blur_stream on an 8x6 frame.
// Build with GAUSSIAN_ROUND_EN defined to check the rounding variant.
`timescale 1ns/1ns
module tb_gaussian_blur_stream;

    localparam int W = 8;
    localparam int H = 6;

`ifdef GAUSSIAN_ROUND_EN
    localparam int C1 = 16;
    localparam int C2 = 32;
    localparam int C4 = 64;
`else
    localparam int C1 = 15;
    localparam int C2 = 31;
    localparam int C4 = 63;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_empty = 1'b1;
    logic [7:0] in_dout = 8'd0;
    logic       out_full = 1'b0;
    logic       in_rd_en;
    logic       out_wr_en;
    logic [7:0] out_din;
    logic       busy;

    gaussian_blur_stream #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_empty  (in_empty),
        .in_dout   (in_dout),
        .in_rd_en  (in_rd_en),
        .out_full  (out_full),
        .out_wr_en (out_wr_en),
        .out_din   (out_din),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] src[$];
    logic [7:0] exp_q[$];
    int         rd_log[$];
    int         wr_log[$];
    bit         busy_log[int];
    logic [7:0] img[H][W];
    logic [7:0] expv[H][W];
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int wr_idx = 0;
    int full_pct = 0;
    int emp_pct = 0;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic int busy_at(input int c);
        return busy_log.exists(c) ? int'(busy_log[c]) : -1;
    endfunction

    function automatic bit is_border(input int r, input int c);
        return (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
    endfunction

    function automatic logic [7:0] gold(input int r, input int c);
        int s;
        int wt;
        if (is_border(r, c)) return 8'd0;
        s = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                wt = (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1);
                s += wt * int'(img[r+dr][c+dc]);
            end
        end
`ifdef GAUSSIAN_ROUND_EN
        s += 8;
        if ((s >> 4) > 255) return 8'd255;
`endif
        return 8'(s >> 4);
    endfunction

    task automatic fill_gold();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                expv[r][c] = gold(r, c);
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'($urandom);
    endtask

    task automatic push_frame();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                src.push_back(img[r][c]);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                exp_q.push_back(expv[r][c]);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
        src.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_log.delete();
    endtask

    // Upstream FIFO and downstream back-pressure model
    initial begin
        bit pop;
        forever begin
            @(negedge clk);
            pop = in_rd_en;
            @(posedge clk);
            #2;
            if (pop && src.size() > 0) void'(src.pop_front());
            in_empty = rst || (src.size() == 0)
                     || (int'($urandom_range(99)) < emp_pct);
            in_dout  = (src.size() > 0) ? src[0] : 8'd0;
            out_full = (int'($urandom_range(99)) < full_pct);
        end
    end

    // Monitor: pops the scoreboard on every downstream write
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                busy_log[cyc] = busy;
                if (in_rd_en) begin
                    rd_log.push_back(cyc);
                    check("rd_while_empty", int'(in_empty), 0);
                end
                if (out_wr_en) begin
                    wr_log.push_back(cyc);
                    check("wr_while_full", int'(out_full), 0);
                    check("exp_avail", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0)
                        check($sformatf("pix%0d", wr_idx), int'(out_din),
                              int'(exp_q.pop_front()));
                    wr_idx++;
                end
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_out_din", int'(out_din), 0);
        check("rst_wr_en", int'(out_wr_en), 0);
        check("rst_rd_en", int'(in_rd_en), 0);
        check("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // constant 100, no stalls
        clear_logs();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                img[r][c]  = 8'd100;
                expv[r][c] = is_border(r, c) ? 8'd0 : 8'd100;
            end
        push_frame();
        drain("const");
        check("n_writes", wr_log.size(), W * H);
        check("first_wr_lat", qat(wr_log, 0) - qat(rd_log, W + 1), 1);
        check("busy_pre", busy_at(qat(rd_log, 0)), 0);
        check("busy_rise", busy_at(qat(rd_log, 0) + 1), 1);
        check("busy_last_wr", busy_at(qat(wr_log, W * H - 1)), 1);
        check("busy_fall", busy_at(qat(wr_log, W * H - 1) + 1), 0);

        // impulse at (2,2)
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                int d;
                img[r][c]  = 8'd0;
                expv[r][c] = 8'd0;
                d = ((r > 2) ? r - 2 : 2 - r) + ((c > 2) ? c - 2 : 2 - c);
                if (r >= 1 && r <= 3 && c >= 1 && c <= 3)
                    expv[r][c] = (d == 0) ? 8'(C4) : (d == 1) ? 8'(C2) : 8'(C1);
            end
        img[2][2] = 8'd255;
        push_frame();
        drain("impulse");

        // all 255: interior stays 255
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                img[r][c]  = 8'd255;
                expv[r][c] = is_border(r, c) ? 8'd0 : 8'd255;
            end
        push_frame();
        drain("sat");

        // random stalls on both sides
        full_pct = 50;
        emp_pct  = 30;
        fill_random();
        fill_gold();
        push_frame();
        drain("stall");
        full_pct = 0;
        emp_pct  = 0;
        repeat (2) @(negedge clk);

        // two frames back to back
        clear_logs();
        fill_random();
        fill_gold();
        push_frame();
        fill_random();
        fill_gold();
        push_frame();
        drain("b2b");
        check("b2b_writes", wr_log.size(), 2 * W * H);
        check("b2b_rd_gap", qat(rd_log, W * H) - qat(rd_log, W * H - 1), W + 2);
        check("b2b_wr_rd", qat(rd_log, W * H), qat(wr_log, W * H - 1));

        // reset during row 3, then a clean frame
        clear_logs();
        fill_random();
        fill_gold();
        push_frame();
        n = 0;
        while (rd_log.size() < 3 * W + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("row3_reached", int'(rd_log.size() >= 3 * W + 2), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        src.delete();
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_out_din", int'(out_din), 0);
        check("mid_rst_wr_en", int'(out_wr_en), 0);
        check("mid_rst_rd_en", int'(in_rd_en), 0);
        check("mid_rst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        fill_random();
        fill_gold();
        push_frame();
        drain("clean");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
